// File: rtl/st7735_spi_rx.sv
// ST7735 4-wire SPI receiver: oversamples cs/dc/sclk/mosi on sys_clk, deserialises
// {dc, byte} words and decodes CASET/RASET/RAMWR into addressed RGB565 pixels.
module st7735_spi_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int COORD_W     = 9
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               spi_cs,
   input  logic               spi_dc,
   input  logic               spi_sclk,
   input  logic               spi_mosi,
   output logic [8:0]         rx_data,
   output logic               rx_valid,
   output logic [7:0]         cmd_code,
   output logic [15:0]        pix_data,
   output logic [COORD_W-1:0] pix_x,
   output logic [COORD_W-1:0] pix_y,
   output logic               pix_valid,
   output logic               frame_err
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CASET, ST_RASET, ST_RAM_HI, ST_RAM_LO
   } state_t;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;
   // Pin order {cs, dc, sclk, mosi}; cs idles high so no edge is seen out of reset.
   localparam logic [3:0] SYNC_RST  = 4'b1000;

   logic [3:0] pin_raw;
   logic [3:0] pin_sync;
   assign pin_raw = {spi_cs, spi_dc, spi_sclk, spi_mosi};

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_sync
         logic [SYNC_STAGES-1:0] chain_reg;
         always_ff @(posedge sys_clk) begin
            if (!sys_rst_n) chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
            else            chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_raw[gi]};
         end
         assign pin_sync[gi] = chain_reg[SYNC_STAGES-1];
      end
   endgenerate

   logic cs_s, dc_s, sclk_s, mosi_s;
   assign {cs_s, dc_s, sclk_s, mosi_s} = pin_sync;

   logic       sclk_prev_reg;
   logic [6:0] shreg_reg;
   logic [2:0] bit_cnt_reg;
   logic [8:0] rx_data_reg;
   logic       rx_valid_reg;
   logic       frame_err_reg;

   logic       sclk_rise;
   logic       byte_done;
   logic [8:0] byte_word;

   assign sclk_rise = sclk_s & ~sclk_prev_reg & ~cs_s;
   assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);
   assign byte_word = {dc_s, shreg_reg, mosi_s};

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         sclk_prev_reg <= 1'b0;
         shreg_reg     <= '0;
         bit_cnt_reg   <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         sclk_prev_reg <= sclk_s;
         rx_valid_reg  <= byte_done;
         if (cs_s) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
            if (bit_cnt_reg != 3'd0) frame_err_reg <= 1'b1;
         end else if (sclk_rise) begin
            // bit_cnt wraps 7 -> 0 on the byte-completing rise
            shreg_reg   <= {shreg_reg[5:0], mosi_s};
            bit_cnt_reg <= bit_cnt_reg + 3'd1;
            if (byte_done) rx_data_reg <= byte_word;
         end
      end
   end

   state_t     state_reg, state_next;
   logic [1:0] idx_reg, idx_next;
   logic       data_byte;

   assign data_byte = byte_done & byte_word[8];

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_reg <= ST_IDLE;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      if (byte_done) begin
         if (!byte_word[8]) begin
            idx_next = '0;
            case (byte_word[7:0])
               CMD_CASET: state_next = ST_CASET;
               CMD_RASET: state_next = ST_RASET;
               CMD_RAMWR: state_next = ST_RAM_HI;
               default:   state_next = ST_IDLE;
            endcase
         end else begin
            case (state_reg)
               ST_CASET, ST_RASET: begin
                  if (idx_reg == 2'd3) begin
                     state_next = ST_IDLE;
                     idx_next   = '0;
                  end else begin
                     idx_next = idx_reg + 2'd1;
                  end
               end
               ST_RAM_HI: state_next = ST_RAM_LO;
               ST_RAM_LO: state_next = ST_RAM_HI;
               default:   state_next = state_reg;
            endcase
         end
      end
   end

   logic [7:0]         cmd_code_reg;
   logic [7:0]         p_sh_reg, p_sl_reg, p_eh_reg, hi_reg;
   logic [COORD_W-1:0] xs_reg, xe_reg, ys_reg, ye_reg;
   logic [COORD_W-1:0] cur_x_reg, cur_y_reg;
   logic [15:0]        pix_data_reg;
   logic [COORD_W-1:0] pix_x_reg, pix_y_reg;
   logic               pix_valid_reg;

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         cmd_code_reg  <= '0;
         p_sh_reg      <= '0;
         p_sl_reg      <= '0;
         p_eh_reg      <= '0;
         hi_reg        <= '0;
         xs_reg        <= '0;
         xe_reg        <= COORD_W'(127);
         ys_reg        <= '0;
         ye_reg        <= COORD_W'(159);
         cur_x_reg     <= '0;
         cur_y_reg     <= '0;
         pix_data_reg  <= '0;
         pix_x_reg     <= '0;
         pix_y_reg     <= '0;
         pix_valid_reg <= 1'b0;
      end else begin
         pix_valid_reg <= data_byte && (state_reg == ST_RAM_LO);
         if (byte_done && !byte_word[8]) begin
            cmd_code_reg <= byte_word[7:0];
            if (byte_word[7:0] == CMD_RAMWR) begin
               cur_x_reg <= xs_reg;
               cur_y_reg <= ys_reg;
            end
         end
         if (data_byte) begin
            case (state_reg)
               ST_CASET, ST_RASET: begin
                  // Window registers change only when the 4th parameter lands.
                  case (idx_reg)
                     2'd0: p_sh_reg <= byte_word[7:0];
                     2'd1: p_sl_reg <= byte_word[7:0];
                     2'd2: p_eh_reg <= byte_word[7:0];
                     default: begin
                        if (state_reg == ST_CASET) begin
                           xs_reg <= COORD_W'({p_sh_reg, p_sl_reg});
                           xe_reg <= COORD_W'({p_eh_reg, byte_word[7:0]});
                        end else begin
                           ys_reg <= COORD_W'({p_sh_reg, p_sl_reg});
                           ye_reg <= COORD_W'({p_eh_reg, byte_word[7:0]});
                        end
                     end
                  endcase
               end
               ST_RAM_HI: hi_reg <= byte_word[7:0];
               ST_RAM_LO: begin
                  pix_data_reg <= {hi_reg, byte_word[7:0]};
                  pix_x_reg    <= cur_x_reg;
                  pix_y_reg    <= cur_y_reg;
                  if (cur_x_reg >= xe_reg) begin
                     cur_x_reg <= xs_reg;
                     cur_y_reg <= (cur_y_reg >= ye_reg) ? ys_reg : cur_y_reg + COORD_W'(1);
                  end else begin
                     cur_x_reg <= cur_x_reg + COORD_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_data   = rx_data_reg;
   assign rx_valid  = rx_valid_reg;
   assign cmd_code  = cmd_code_reg;
   assign pix_data  = pix_data_reg;
   assign pix_x     = pix_x_reg;
   assign pix_y     = pix_y_reg;
   assign pix_valid = pix_valid_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_st7735_spi_rx.sv
// Directed bench for st7735_spi_rx: bit-bangs SPI bytes at a 2-cycle half period
// and checks decoded words, window/cursor behaviour, framing errors and reset.
module tb_st7735_spi_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_cs, spi_dc, spi_sclk, spi_mosi;
   logic [8:0] rx_data;
   logic       rx_valid;
   logic [7:0] cmd_code;
   logic [15:0] pix_data;
   logic [8:0] pix_x, pix_y;
   logic       pix_valid;
   logic       frame_err;

   st7735_spi_rx #(.SYNC_STAGES(2), .COORD_W(9)) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .spi_cs    (spi_cs),
      .spi_dc    (spi_dc),
      .spi_sclk  (spi_sclk),
      .spi_mosi  (spi_mosi),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .cmd_code  (cmd_code),
      .pix_data  (pix_data),
      .pix_x     (pix_x),
      .pix_y     (pix_y),
      .pix_valid (pix_valid),
      .frame_err (frame_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int rx_count = 0;
   int rx_cyc = 0;
   int last_rise_cyc = 0;
   logic [15:0] pq_data[$];
   logic [8:0]  pq_x[$];
   logic [8:0]  pq_y[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample outputs 1 time unit after each rising edge.
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rx_valid) begin
         rx_count++;
         rx_cyc = cyc;
      end
      if (pix_valid) begin
         pq_data.push_back(pix_data);
         pq_x.push_back(pix_x);
         pq_y.push_back(pix_y);
      end
   end

   task automatic send_bits(input logic dc, input logic [7:0] b, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) begin
         @(negedge clk);
         spi_dc = dc; spi_mosi = b[i]; spi_sclk = 1'b0;
         @(negedge clk);
         @(negedge clk);
         spi_sclk = 1'b1;
         last_rise_cyc = cyc + 1;
         @(negedge clk);
      end
      @(negedge clk);
      spi_sclk = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic send_byte(input logic dc, input logic [7:0] b);
      $display("tx dc=%0d byte=%02h", dc, b);
      send_bits(dc, b, 8);
   endtask

   task automatic cs_set(input logic v);
      @(negedge clk);
      spi_cs = v;
      repeat (4) @(negedge clk);
   endtask

   localparam int NPIX = 7;
   int exp_x[NPIX] = '{2, 3, 4, 2, 3, 4, 2};
   int exp_y[NPIX] = '{5, 5, 5, 6, 6, 6, 5};

   initial begin
      int rx0;
      rst_n = 1'b0; spi_cs = 1'b1; spi_dc = 1'b0; spi_sclk = 1'b0; spi_mosi = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_cmd_code", cmd_code, 0);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_frame_err", frame_err, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // single command byte, with latency check
      cs_set(1'b0);
      send_byte(1'b0, 8'h2A);
      check("t1_rx_count", rx_count, 1);
      check("t1_rx_data", rx_data, 9'h02A);
      check("t1_cmd_code", cmd_code, 8'h2A);
      check("t1_frame_err", frame_err, 0);
      check("t1_latency", rx_cyc - last_rise_cyc, 2);

      // aborted CASET leaves default window
      send_byte(1'b0, 8'h2A);
      send_byte(1'b1, 8'h00);
      send_byte(1'b1, 8'h09);
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'h12);
      send_byte(1'b1, 8'h34);
      check("t3_pix_count", pq_data.size(), 1);
      if (pq_data.size() == 1) begin
         check("t3_pix_data", pq_data[0], 16'h1234);
         check("t3_pix_x", pq_x[0], 0);
         check("t3_pix_y", pq_y[0], 0);
      end
      pq_data.delete(); pq_x.delete(); pq_y.delete();

      // window 2..4 x 5..6, seven pixels with wrap
      send_byte(1'b0, 8'h2A);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h02);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h04);
      send_byte(1'b0, 8'h2B);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h06);
      send_byte(1'b0, 8'h2C);
      for (int i = 0; i < NPIX; i++) begin
         send_byte(1'b1, 8'hF8);
         send_byte(1'b1, 8'(i));
      end
      check("t2_pix_count", pq_data.size(), NPIX);
      for (int i = 0; i < NPIX && i < pq_data.size(); i++) begin
         $display("pix %0d data=%04h x=%0d y=%0d", i, pq_data[i], pq_x[i], pq_y[i]);
         check($sformatf("t2_data%0d", i), pq_data[i], 32'hF800 + i);
         check($sformatf("t2_x%0d", i), pq_x[i], exp_x[i]);
         check($sformatf("t2_y%0d", i), pq_y[i], exp_y[i]);
      end
      pq_data.delete(); pq_x.delete(); pq_y.delete();
      cs_set(1'b1);

      // cs raised after 5 bits
      rx0 = rx_count;
      cs_set(1'b0);
      send_bits(1'b1, 8'hFF, 5);
      cs_set(1'b1);
      check("t4_no_rx", rx_count - rx0, 0);
      check("t4_frame_err", frame_err, 1);
      cs_set(1'b0);
      send_byte(1'b1, 8'hA5);
      check("t4_rx_count", rx_count - rx0, 1);
      check("t4_rx_data", rx_data, 9'h1A5);
      check("t4_err_sticky", frame_err, 1);

      // reset after RAMWR hi byte
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'hAB);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("t5_rx_data", rx_data, 0);
      check("t5_cmd_code", cmd_code, 0);
      check("t5_pix_data", pix_data, 0);
      check("t5_pix_xy", {pix_x, pix_y}, 0);
      check("t5_frame_err", frame_err, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      pq_data.delete(); pq_x.delete(); pq_y.delete();
      send_byte(1'b0, 8'h2C);
      send_byte(1'b1, 8'hAB);
      send_byte(1'b1, 8'hCD);
      check("t5_pix_count", pq_data.size(), 1);
      if (pq_data.size() == 1) begin
         check("t5_new_pix", pq_data[0], 16'hABCD);
         check("t5_new_x", pq_x[0], 0);
         check("t5_new_y", pq_y[0], 0);
      end
      pq_data.delete(); pq_x.delete(); pq_y.delete();

      // unsupported command then data: no pixels
      rx0 = rx_count;
      send_byte(1'b0, 8'h11);
      send_byte(1'b1, 8'h55);
      send_byte(1'b1, 8'h66);
      check("t6_rx_count", rx_count - rx0, 3);
      check("t6_cmd_code", cmd_code, 8'h11);
      check("t6_rx_data", rx_data, 9'h166);
      check("t6_no_pix", pq_data.size(), 0);
      cs_set(1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
